// File: rtl/xnor_gate.sv
// xnor_gate: 4-input XNOR (even-parity detector) leaf cell.
//   y          : combinational parity result, zero latency.
//   y_q        : y captured on every accepted (in_valid) cycle.
//   out_valid  : in_valid delayed by one cycle.
//   err_cnt    : saturating count of accepted samples with y=0.
//   sticky_err : set by the first accepted y=0 sample, held until cnt_clr.
// Optional build macro XNOR_GATE_INVERT_EN adds an 'inv' input. With inv=1,
// y becomes plain XOR (odd parity), so the counter then tallies even-parity
// samples. In that build the y_q reset value is 0.
// CNT_W legal range is 2..16.
module xnor_gate #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             in_valid,
    input  logic             cnt_clr,
`ifdef XNOR_GATE_INVERT_EN
    input  logic             inv,
`endif
    output logic             y,
    output logic             y_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sticky_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef XNOR_GATE_INVERT_EN
    // Reset value is a constant so the async reset stays a plain reset/preset.
    localparam logic Y_Q_RST = 1'b0;
`else
    // All-zero input is even parity, so the idle registered result is 1.
    localparam logic Y_Q_RST = 1'b1;
`endif

    logic [3:0]       data_bits;
    logic [4:0]       par_chain;
    logic             y_comb;

    logic             y_q_reg;
    logic             y_q_next;
    logic             out_valid_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [CNT_W-1:0] err_cnt_next;
    logic             sticky_err_reg;
    logic             sticky_err_next;

    assign data_bits    = {d, c, b, a};
    assign par_chain[0] = 1'b0;

    // XOR chain across the data bits; par_chain[4] is the odd-parity flag.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ data_bits[gi];
        end
    endgenerate

`ifdef XNOR_GATE_INVERT_EN
    // inv=1 flips the sense: y reports odd parity instead of even parity.
    assign y_comb = ~(par_chain[4] ^ inv);
`else
    assign y_comb = ~par_chain[4];
`endif

    // Next-state logic: capture on valid; clear beats a simultaneous y=0 sample.
    always_comb begin
        y_q_next        = in_valid ? y_comb : y_q_reg;
        err_cnt_next    = err_cnt_reg;
        sticky_err_next = sticky_err_reg;
        if (cnt_clr) begin
            err_cnt_next    = '0;
            sticky_err_next = 1'b0;
        end else if (in_valid && !y_comb) begin
            if (err_cnt_reg != CNT_MAX) begin
                err_cnt_next = err_cnt_reg + CNT_ONE;
            end
            sticky_err_next = 1'b1;
        end
    end

    // State registers with asynchronous reset to the idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_reg        <= Y_Q_RST;
            out_valid_reg  <= 1'b0;
            err_cnt_reg    <= '0;
            sticky_err_reg <= 1'b0;
        end else begin
            y_q_reg        <= y_q_next;
            out_valid_reg  <= in_valid;
            err_cnt_reg    <= err_cnt_next;
            sticky_err_reg <= sticky_err_next;
        end
    end

    assign y          = y_comb;
    assign y_q        = y_q_reg;
    assign out_valid  = out_valid_reg;
    assign err_cnt    = err_cnt_reg;
    assign sticky_err = sticky_err_reg;

endmodule

// File: tb/tb_xnor_gate.sv
// Self-checking bench for xnor_gate: a default-width instance and a CNT_W=2
// instance share the stimulus; a parity model computed with $countones
// predicts every output each cycle, and literal checks pin key scenarios.
module tb_xnor_gate;

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, c, d;
    logic       in_valid;
    logic       cnt_clr;

    logic       y, y_q, out_valid, sticky_err;
    logic [7:0] err_cnt;
    logic       y2, y_q2, out_valid2, sticky_err2;
    logic [1:0] err_cnt2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_yq, m_ov, m_cnt8, m_cnt2, m_st;

    xnor_gate #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y(y), .y_q(y_q), .out_valid(out_valid),
        .err_cnt(err_cnt), .sticky_err(sticky_err)
    );

    xnor_gate #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y(y2), .y_q(y_q2), .out_valid(out_valid2),
        .err_cnt(err_cnt2), .sticky_err(sticky_err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int even_of(input logic [3:0] v);
        return (($countones(v) % 2) == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_yq = 1; m_ov = 0; m_cnt8 = 0; m_cnt2 = 0; m_st = 0;
    endtask

    // One rising edge of the spec: valid capture, delay, saturating count.
    task automatic model_clock();
        int ev;
        ev = even_of({a, b, c, d});
        if (in_valid) m_yq = ev;
        m_ov = in_valid ? 1 : 0;
        if (cnt_clr) begin
            m_cnt8 = 0; m_cnt2 = 0; m_st = 0;
        end else if (in_valid && ev == 0) begin
            m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
            m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
            m_st   = 1;
        end
    endtask

    task automatic compare_all();
        int ev;
        ev = even_of({a, b, c, d});
        chk("y", int'(y), ev);
        chk("y2", int'(y2), ev);
        chk("y_q", int'(y_q), m_yq);
        chk("y_q2", int'(y_q2), m_yq);
        chk("out_valid", int'(out_valid), m_ov);
        chk("out_valid2", int'(out_valid2), m_ov);
        chk("err_cnt", int'(err_cnt), m_cnt8);
        chk("err_cnt2", int'(err_cnt2), m_cnt2);
        chk("sticky_err", int'(sticky_err), m_st);
        chk("sticky_err2", int'(sticky_err2), m_st);
    endtask

    // Apply inputs mid-cycle, let one rising edge pass, check at the falling edge.
    task automatic step(input logic [3:0] abcd, input logic v, input logic clr);
        {a, b, c, d} = abcd;
        in_valid     = v;
        cnt_clr      = clr;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
        $display("step abcd=%b v=%b clr=%b y_q=%b ov=%b cnt=%0d cnt2=%0d sticky=%b",
                 abcd, v, clr, y_q, out_valid, err_cnt, err_cnt2, sticky_err);
    endtask

    initial begin
        logic [15:0] sweep_exp;
        logic [3:0]  code;
        logic [3:0]  cnt_seq [8];

        sweep_exp = 16'b1001_0110_0110_1001;
        rst = 1'b1;
        {a, b, c, d} = 4'b0000;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        model_reset();
        #12 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        compare_all();
        chk("reset_y_q", int'(y_q), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);

        // Exhaustive combinational sweep, 10 time units per code.
        for (int i = 0; i < 16; i++) begin
            code = i[3:0];
            {a, b, c, d} = code;
            #5;
            chk("sweep_y", int'(y), int'(sweep_exp[15-i]));
            $display("sweep abcd=%b y=%b", code, y);
            #5;
        end
        {a, b, c, d} = 4'b0000;
        @(negedge clk);

        // Registered path after a reset pulse.
        #2 rst = 1'b1;
        #1 model_reset();
        #1 rst = 1'b0;
        step(4'b0001, 1'b1, 1'b0);
        chk("reg_y_q", int'(y_q), 0);
        chk("reg_out_valid", int'(out_valid), 1);
        step(4'b0000, 1'b0, 1'b0);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_y_q_hold", int'(y_q), 0);

        // Counter: 5 odd and 3 even accepted samples.
        step(4'b0000, 1'b0, 1'b1);
        cnt_seq = '{4'b0111, 4'b0011, 4'b0111, 4'b0111,
                    4'b0011, 4'b0111, 4'b0011, 4'b0111};
        for (int i = 0; i < 8; i++) step(cnt_seq[i], 1'b1, 1'b0);
        chk("count_err_cnt", int'(err_cnt), 5);
        chk("count_sticky", int'(sticky_err), 1);

        // Saturation of the 2-bit counter.
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0111, 1'b1, 1'b0);
        chk("sat_err_cnt2", int'(err_cnt2), 3);
        chk("sat_err_cnt", int'(err_cnt), 6);

        // Clear wins over a simultaneous odd sample.
        step(4'b0111, 1'b1, 1'b1);
        chk("clr_err_cnt", int'(err_cnt), 0);
        chk("clr_sticky", int'(sticky_err), 0);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b1, 1'b0);
        chk("pre_rst_err_cnt", int'(err_cnt), 4);
        #3 rst = 1'b1;
        #1;
        chk("async_err_cnt", int'(err_cnt), 0);
        chk("async_y_q", int'(y_q), 1);
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_sticky", int'(sticky_err), 0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        compare_all();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 24) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
